// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 8x8 multiplier, operands held MUL_CYCLES cycles.
// Define MULT_SHARE_ZERO_SKIP_EN to answer zero-operand requests directly without the BUSY phase.
module multiplier_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] pp  [8];
    logic [15:0] acc [9];
    assign acc[0] = '0;
    for (genvar r = 0; r < 8; r++) begin : g_row
        assign pp[r]    = b[r] ? (16'(a) << r) : '0;
        assign acc[r+1] = acc[r] + pp[r];
    end
    assign p = acc[8];
endmodule

module mult_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_product,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] ptr, grant_id, id_q;
    logic [ID_W:0]   idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]      op_a, op_b, sel_a, sel_b;
    logic [15:0]     product;
    logic            any_req, accept, zero_skip, mul_done;

    multiplier_8 u_mul (.a(op_a), .b(op_b), .p(product));

    // Scan downward so the candidate closest to ptr is the last (winning) assignment.
    always_comb begin
        any_req  = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(off);
            if (idx >= (ID_W + 1)'(NUM_REQ)) idx = idx - (ID_W + 1)'(NUM_REQ);
            if (req_valid[idx[ID_W-1:0]]) begin
                any_req  = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
    end

    assign sel_a     = req_a[{grant_id, 3'b000} +: 8];
    assign sel_b     = req_b[{grant_id, 3'b000} +: 8];
    assign accept    = (state == IDLE) && any_req;
    assign req_ready = (accept && !rst) ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy      = (state != IDLE);
    assign mul_done  = (state == BUSY) && (cnt == '0);
`ifdef MULT_SHARE_ZERO_SKIP_EN
    assign zero_skip = (sel_a == 8'd0) || (sel_b == 8'd0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = zero_skip ? DONE : BUSY;
            BUSY:    if (cnt == '0) state_next = DONE;
            DONE:    if (rsp_valid && rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            id_q        <= '0;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= '0;
        end else begin
            if (accept) begin
                ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                op_a <= sel_a;
                op_b <= sel_b;
                id_q <= grant_id;
                cnt  <= CNT_W'(MUL_CYCLES - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (mul_done || (accept && zero_skip)) begin
                rsp_valid   <= 1'b1;
                rsp_product <= mul_done ? product : '0;
                rsp_id      <= mul_done ? id_q : grant_id;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: scoreboard bench with a round-robin reference model for mult_share_arbiter.
module tb_mult_share_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int MUL_CYCLES = 2;
`ifdef MULT_SHARE_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    typedef struct { int id; int prod; int due; } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a, req_b;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [15:0]          rsp_product;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;
    logic [7:0]           av [NUM_REQ] = '{default: 8'd0};
    logic [7:0]           bv [NUM_REQ] = '{default: 8'd0};

    exp_t sb [$];
    int   ptr_m = 0;
    bit   free_m = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc_cnt [NUM_REQ] = '{default: 0};
    int   seen    [NUM_REQ] = '{default: 0};
    int   g;
    bit   ev;
    logic [NUM_REQ-1:0] er;

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[8*i +: 8] = av[i];
            req_b[8*i +: 8] = bv[i];
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    // Reference model: grant = first valid requester at or after ptr (mod NUM_REQ), one job in flight.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            #1;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_product", 32'(rsp_product), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            sb.delete();
            ptr_m  = 0;
            free_m = 1'b1;
        end else begin
            g = -1;
            if (free_m)
                for (int j = 0; j < NUM_REQ; j++)
                    if (g < 0 && req_valid[(ptr_m + j) % NUM_REQ]) g = (ptr_m + j) % NUM_REQ;
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(!free_m));
            ev = (sb.size() > 0) && (cyc >= sb[0].due);
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rsp_product", 32'(rsp_product), 32'(sb[0].prod));
                chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    free_m = 1'b1;
                end
            end
            if (g >= 0) begin
                sb.push_back('{g, int'(av[g]) * int'(bv[g]),
                    cyc + ((ZERO_SKIP && (av[g] == 0 || bv[g] == 0)) ? 1 : MUL_CYCLES + 1)});
                ptr_m  = (g + 1) % NUM_REQ;
                free_m = 1'b0;
                acc_cnt[g]++;
            end
        end
    end

    function automatic logic [7:0] rnd8();
        return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int i);
        for (int n = 0; n < 60; n++) begin
            tick();
            if (acc_cnt[i] != seen[i]) begin
                seen[i] = acc_cnt[i];
                return;
            end
        end
        $display("FAIL wait_acc: requester %0d got no grant, expected one within 60 cycles", i);
        $fatal(1, "grant timeout");
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (sb.size() == 0 && free_m) begin
                seen = acc_cnt;
                return;
            end
        end
        $display("FAIL drain: %0d responses outstanding, expected 0 within 60 cycles", sb.size());
        $fatal(1, "drain timeout");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        // 0xFF * 0xFF from requester 1
        tick();
        av[1] = 8'hFF; bv[1] = 8'hFF; req_valid = 4'b0010;
        wait_acc(1);
        drain();
        // reset back to ptr 0, then all four continuously requesting
        #2 rst = 1'b1;
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin av[i] = rnd8(); bv[i] = rnd8(); end
        req_valid = 4'b1111;
        for (int n = 0, k = 0; k < 5 && n < 60; n++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++)
                if (acc_cnt[i] != seen[i]) begin
                    seen[i] = acc_cnt[i];
                    av[i] = rnd8(); bv[i] = rnd8();
                    k++;
                end
        end
        drain();
        // backpressure: response held for 5 extra cycles while requester 0 waits
        rsp_ready = 1'b0;
        av[2] = 8'h12; bv[2] = 8'h34; req_valid = 4'b0100;
        wait_acc(2);
        av[0] = rnd8(); bv[0] = rnd8(); req_valid = 4'b0001;
        repeat (MUL_CYCLES + 6) tick();
        rsp_ready = 1'b1;
        wait_acc(0);
        drain();
        // asynchronous reset in the middle of BUSY
        av[0] = 8'h55; bv[0] = 8'h66; req_valid = 4'b0001;
        wait_acc(0);
        #2 rst = 1'b1;
        av[1] = 8'h21; bv[1] = 8'h03; av[3] = 8'h7F; bv[3] = 8'h02; req_valid = 4'b1010;
        tick();
        #2 rst = 1'b0;
        wait_acc(1);
        req_valid[1] = 1'b0;
        wait_acc(3);
        drain();
        // pointer wrap: serve 2, then 3 and 0 both request
        av[2] = rnd8(); bv[2] = rnd8(); req_valid = 4'b0100;
        wait_acc(2);
        drain();
        av[0] = 8'h09; bv[0] = 8'h0B; av[3] = 8'hC3; bv[3] = 8'h5A; req_valid = 4'b1001;
        wait_acc(3);
        req_valid[3] = 1'b0;
        wait_acc(0);
        drain();
        // zero operand
        av[1] = 8'h00; bv[1] = 8'h37; req_valid = 4'b0010;
        wait_acc(1);
        drain();
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_cnt[i] != seen[i]) begin
                    seen[i] = acc_cnt[i];
                    req_valid[i] = 1'($urandom_range(0, 1));
                    av[i] = rnd8(); bv[i] = rnd8();
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        av[i] = rnd8(); bv[i] = rnd8();
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 8x8 combinational array multiplier (multiplier_8) between NUM_REQ requesters using round-robin arbitration.
- Registers the operands of the granted requester and holds them stable for MUL_CYCLES cycles, treating the multiplier as a multicycle path.
- Captures the 16-bit product and returns it with the requester ID over a valid/ready response channel.
- Sits between the requesting datapath units and the shared multiplier instance.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..16.
- ID_W, 2: width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
- MUL_CYCLES, 2: cycles the operands are held before the product is sampled, minimum 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
- req_a  in  NUM_REQ*8  multiplicands; requester i uses [8*i+7:8*i].
- req_b  in  NUM_REQ*8  multipliers; same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted by the consumer.
- rsp_product  out  16  unsigned product a*b.
- rsp_id  out  ID_W  index of the requester that produced the result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States and transitions:
  - IDLE: if any req_valid is high, grant one requester, latch its a/b into op_a/op_b and its index into id_q, load cnt=MUL_CYCLES-1, go to BUSY. If no request, stay in IDLE; the pointer is unchanged.
  - BUSY: op_a/op_b drive the multiplier and stay stable. Decrement cnt each cycle. When cnt==0, register the multiplier output into rsp_product, id_q into rsp_id, set rsp_valid, go to DONE.
  - DONE: hold rsp_valid, rsp_product and rsp_id stable. When rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
- Arbitration:
  - Combinational search starting at pointer ptr. The first i in order ptr, ptr+1, ... (mod NUM_REQ) with req_valid[i] high is granted.
  - req_ready[i] = (state==IDLE) && grant[i] && !rst.
  - On accept of requester i, ptr <= (i+1) mod NUM_REQ. Wrap is correct for NUM_REQ not a power of two.
- Handshake rules:
  - A request is accepted in the cycle where req_valid[i]&&req_ready[i] is high.
  - A requester holds valid and operands until accepted. Valid must not depend on ready.
  - Dropping valid before accept is legal; the request is simply not served.
- Latency: accept in cycle k gives first rsp_valid in cycle k+MUL_CYCLES+1.
- Throughput: with rsp_ready tied high, one accept per MUL_CYCLES+2 cycles. The DONE-exit cycle and the next IDLE grant cycle never overlap.
- Backpressure: while in BUSY or DONE, all req_ready are 0 regardless of req_valid.
- If rsp_ready is already high in the first rsp_valid cycle, the transfer completes in that cycle and the block is in IDLE on the next cycle.
- Reset, asynchronous and valid at any time including mid-BUSY or mid-DONE:
  - state=IDLE, ptr=0, cnt=0, op_a=op_b=0, id_q=0.
  - rsp_valid=0, rsp_product=0, rsp_id=0, busy=0, req_ready=0.
  - Any in-flight operation is discarded; no response is produced for it.
- Arithmetic: unsigned 8x8 to 16 bits. The full product is always representable, so there is no overflow case.

Optional Feature:
- Macro MULT_SHARE_ZERO_SKIP_EN.
- Defined: in IDLE, if the granted a==0 or b==0, the block skips BUSY. It loads rsp_product=0, rsp_id=i, rsp_valid=1 directly and goes to DONE, so first rsp_valid is in cycle k+1.
- Not defined: zero operands take the normal BUSY path with latency MUL_CYCLES+1.
- Arbitration and pointer update are identical in both builds.

Test Plan:
- NUM_REQ=4, MUL_CYCLES=2: requester 1 sends a=0xFF, b=0xFF, accepted in cycle k -> rsp_valid first high in cycle k+3, rsp_product=0xFE01, rsp_id=1, busy high cycles k+1..k+3.
- All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0, one accept every 4 cycles, products match each requester's a*b.
- rsp_ready low for 5 cycles after rsp_valid with a=0x12, b=0x34 -> rsp_valid, rsp_product=0x03A8 and rsp_id stay stable; req_ready stays 0; IDLE entered one cycle after rsp_ready rises.
- Assert rst during BUSY -> rsp_valid, busy and req_ready go 0 without waiting for a clock edge. After release, ptr=0: with req_valid=4'b1010, requester 1 is granted first and no stale response appears.
- ptr=3 after serving requester 2, then req_valid=4'b1001 -> requester 3 is granted, then ptr wraps to 0 and requester 0 is granted next.
- a=0x00, b=0x37 accepted in cycle k -> product 0x0000. First rsp_valid in cycle k+1 with MULT_SHARE_ZERO_SKIP_EN defined, cycle k+3 without.
